sfifo_cfg: RTL



---
 rtl/sfifo_cfg.sv | 88 ++++++++
 1 files changed

// File: rtl/sfifo_cfg.sv
// sfifo_cfg: single-clock FIFO with FWFT option, programmable almost
// thresholds, occupancy level, synchronous flush and sticky error flags.
module sfifo_cfg #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 4,
   parameter bit FWFT       = 1'b0
) (
   input  logic                  i_clk,
   input  logic                  i_reset_n,
   input  logic                  i_flush,
   input  logic [DATA_WIDTH-1:0] i_wdata,
   input  logic                  i_winc,
   input  logic                  i_rinc,
   input  logic [ADDR_WIDTH:0]   i_ae_thresh,
   input  logic [ADDR_WIDTH:0]   i_af_thresh,
   output logic [DATA_WIDTH-1:0] o_rdata,
   output logic [ADDR_WIDTH:0]   o_level,
   output logic                  o_wfull,
   output logic                  o_wfull_almost,
   output logic                  o_rempty,
   output logic                  o_rempty_almost,
   output logic                  o_overflow,
   output logic                  o_underflow
);

   localparam int DEPTH = 1 << ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0] FULL_LVL = (ADDR_WIDTH+1)'(DEPTH);

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [ADDR_WIDTH-1:0] wr_ptr;
   logic [ADDR_WIDTH-1:0] rd_ptr;
   logic [ADDR_WIDTH:0]   level;
   logic                  ovf;
   logic                  udf;
   logic                  we;
   logic                  re;

   assign o_level         = level;
   assign o_wfull         = (level == FULL_LVL);
   assign o_rempty        = (level == '0);
   assign o_wfull_almost  = (level >= i_af_thresh);
   assign o_rempty_almost = (level <= i_ae_thresh);
   assign o_overflow      = ovf;
   assign o_underflow     = udf;

   // flush wins over any same-cycle access
   assign we = i_winc & ~o_wfull & ~i_flush;
   assign re = i_rinc & ~o_rempty & ~i_flush;

   always_ff @(posedge i_clk) begin
      if (we) mem[wr_ptr] <= i_wdata;
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
         ovf    <= 1'b0;
         udf    <= 1'b0;
      end else if (i_flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
         ovf    <= 1'b0;
         udf    <= 1'b0;
      end else begin
         if (we) wr_ptr <= wr_ptr + 1'b1;
         if (re) rd_ptr <= rd_ptr + 1'b1;
         if (we && !re)      level <= level + 1'b1;
         else if (re && !we) level <= level - 1'b1;
         if (i_winc && o_wfull)  ovf <= 1'b1;
         if (i_rinc && o_rempty) udf <= 1'b1;
      end
   end

   if (FWFT) begin : g_fwft
      assign o_rdata = mem[rd_ptr];
   end else begin : g_std
      logic [DATA_WIDTH-1:0] rdata_q;
      always_ff @(posedge i_clk or negedge i_reset_n) begin
         if (!i_reset_n) rdata_q <= '0;
         else if (re)    rdata_q <= mem[rd_ptr];
      end
      assign o_rdata = rdata_q;
   end

endmodule
